interval_meter: RTL and testbench



---
 rtl/interval_meter.sv | 91 +++++++++
 tb/tb_interval_meter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/interval_meter.sv
// Start/stop interval meter: counts CLK cycles from a START edge to a STOP edge
// and reports the result with a one-cycle valid strobe, timing out at MAX_COUNT.
module interval_meter #(
    parameter int WIDTH     = 21,
    parameter int MAX_COUNT = 2**21-1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] count_out_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MEASURE = 2'b01
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] cnt_inc;

    // Counter stays below MAX_COUNT, so the increment never wraps.
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                cnt_d = cnt_inc;
                if (stop_i) begin
                    count_d = cnt_inc;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (cnt_inc == MAX_C) begin
                    count_d = MAX_C;
                    valid_d = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign count_out_o = count_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_interval_meter.sv
// Directed bench for interval_meter with MAX_COUNT = 8; expected values are hand-computed.
module tb_interval_meter;

    localparam int WIDTH = 21;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             stop_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] count_out_o;
    logic             overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    interval_meter #(.WIDTH(WIDTH), .MAX_COUNT(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .count_out_o (count_out_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (valid_o === 1'b1) n_valid++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_result(input string tag, input int cnt, input logic ovf);
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_count"}, 32'(count_out_o), 32'(cnt));
        check({tag, "_ovf"}, 32'(overflow_o), 32'(ovf));
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_count", 32'(count_out_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        rst_i = 1'b0;
        tick();

        // 1: interval of 5
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("t1_busy_rise", 32'(busy_o), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_busy_mid", 32'(busy_o), 1);
            check("t1_novalid", 32'(valid_o), 0);
        end
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t1", 5, 1'b0);
        tick();
        check("t1_valid_width", 32'(valid_o), 0);
        check("t1_hold", 32'(count_out_o), 5);

        // 2: minimum interval, then coincident start/stop
        start_i = 1'b1; tick(); start_i = 1'b0;
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t2_min", 1, 1'b0);
        tick();
        start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
        check("t2_coinc_busy", 32'(busy_o), 1);
        check("t2_coinc_novalid", 32'(valid_o), 0);
        tick(); tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t2_three", 3, 1'b0);
        tick();

        // 3: timeout at MAX_COUNT = 8, then stop exactly on the boundary
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t3_pre_timeout", 32'(valid_o), 0);
        end
        tick();
        check_result("t3_timeout", 8, 1'b1);
        tick();
        check("t3_ovf_width", 32'(overflow_o), 0);
        check("t3_idle", 32'(busy_o), 0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t3_stop_at_max", 8, 1'b0);
        tick();

        // 4: start ignored during measure, stop ignored in idle
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t4_restart_ignored", 6, 1'b0);
        tick();
        check("t4_pulses", 32'(n_valid), 6);
        stop_i = 1'b1; tick(); tick(); stop_i = 1'b0; tick();
        check("t4_idle_stop_novalid", 32'(n_valid), 6);
        check("t4_idle_stop_hold", 32'(count_out_o), 6);
        check("t4_idle_stop_busy", 32'(busy_o), 0);

        // 5: async reset mid-measure
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_i = 1'b1;
        #1;
        check("t5_rst_busy", 32'(busy_o), 0);
        check("t5_rst_count", 32'(count_out_o), 0);
        check("t5_rst_valid", 32'(valid_o), 0);
        check("t5_rst_ovf", 32'(overflow_o), 0);
        tick();
        rst_i = 1'b0;
        tick(); tick();
        check("t5_no_valid_after", 32'(n_valid), 6);
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t5_after_rst", 2, 1'b0);
        tick();

        // 6: back-to-back measurements
        start_i = 1'b1; tick(); start_i = 1'b0;
        tick(); tick(); tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t6_first", 4, 1'b0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("t6_b2b_busy", 32'(busy_o), 1);
        check("t6_b2b_valid_low", 32'(valid_o), 0);
        tick(); tick();
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        check_result("t6_second", 3, 1'b0);
        tick(); tick();
        check("total_valid_pulses", 32'(n_valid), 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
